fifo_wr_arbiter: RTL and testbench

//   Write-side controller for the async FIFO. Shares the single FIFO write port among NREQ

---
 rtl/fifo_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 56 +++++
 tb/tb_fifo_wr_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer type and gray/binary conversion helpers for the async FIFO
package fifo_pkg;
  localparam int PTR_W = 5;
  typedef logic [PTR_W-1:0] ptr_t;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; scan starts after the last winner, which moves only on advance
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic            adv,
  output logic [NREQ-1:0] gnt
);
  localparam int LW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [LW-1:0] last_gnt, win, idx;
  logic found;
  always_comb begin
    gnt = '0;
    win = last_gnt;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last_gnt) + k) % NREQ);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) last_gnt <= LW'(NREQ - 1);
    else if (adv) last_gnt <= win;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin shared FIFO write port, write pointer and full flag (FIFO_WR_ALMOST_FULL_EN adds walmost_full)
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int DSIZE        = 8,
  parameter int NREQ         = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [ADDRSIZE:0]     wq2_rptr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  winc,
  output logic [ADDRSIZE-1:0]   waddr,
  output logic [DSIZE-1:0]      wdata,
  output logic [ADDRSIZE:0]     wptr,
  output logic                  wfull,
  output logic                  walmost_full
);
  logic [ADDRSIZE:0] wbin, wbin_next, wgray_next;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(wclk), .rst_n(wrst_n), .req(req), .en(wrst_n && !wfull), .adv(winc), .gnt(gnt)
  );
  assign winc = |gnt;
  assign waddr = wbin[ADDRSIZE-1:0];
  assign wbin_next = wbin + (ADDRSIZE+1)'(winc);
  assign wgray_next = (ADDRSIZE+1)'(bin2gray(32'(wbin_next)));
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) wdata = wdata | (gnt[i] ? req_data[i*DSIZE +: DSIZE] : '0);
  end
  // full when the next write pointer has lapped the read pointer by exactly one depth
  always_ff @(posedge wclk)
    if (!wrst_n) begin
      wbin <= '0;
      wptr <= '0;
      wfull <= 1'b0;
    end else begin
      wbin <= wbin_next;
      wptr <= wgray_next;
      wfull <= wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    end
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic [ADDRSIZE:0] rbin, used;
  assign rbin = (ADDRSIZE+1)'(gray2bin(32'(wq2_rptr)));
  assign used = wbin_next - rbin;
  always_ff @(posedge wclk)
    if (!wrst_n) walmost_full <= 1'b0;
    else walmost_full <= ((2**ADDRSIZE) - int'(used)) <= AFULL_THRESH;
`else
  assign walmost_full = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vectors for reset, round-robin, fill, drain/wrap, idle skip and almost-full
module tb_fifo_wr_arbiter;
  localparam int A = 4, D = 8, N = 4;
  logic wclk = 1'b0, wrst_n = 1'b0;
  logic [A:0] wq2_rptr = '0;
  logic [N-1:0] req = '0;
  logic [N*D-1:0] req_data = 32'hD3C2B1A0;
  logic [N-1:0] gnt;
  logic winc, wfull, walmost_full;
  logic [A-1:0] waddr;
  logic [D-1:0] wdata;
  logic [A:0] wptr;
  int total = 0, bad = 0;
  fifo_wr_arbiter #(.ADDRSIZE(A), .DSIZE(D), .NREQ(N), .AFULL_THRESH(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .wq2_rptr(wq2_rptr), .req(req), .req_data(req_data),
    .gnt(gnt), .winc(winc), .waddr(waddr), .wdata(wdata), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full)
  );
  always #5 wclk = ~wclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge wclk);
    #1;
  endtask
  function automatic logic [A:0] g(input int b);
    logic [A:0] x;
    x = (A+1)'(b);
    return x ^ (x >> 1);
  endfunction
  initial begin
    req = 4'hF;
    tick;
    tick;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_winc", 32'(winc), 0);
    chk("rst_wptr", 32'(wptr), 0);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_afull", 32'(walmost_full), 0);
    wrst_n = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      chk("rr_waddr", 32'(waddr), 32'(k));
      chk("rr_wdata", 32'(wdata), 32'(8'hA0 + 8'h11 * (k % 4)));
      tick;
      chk("rr_wptr", 32'(wptr), 32'(g(k + 1)));
      wq2_rptr = g(k + 1);
      #1;
    end
    wrst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    tick;
    chk("midrst_wptr", 32'(wptr), 0);
    chk("midrst_wfull", 32'(wfull), 0);
    wq2_rptr = '0;
    req = 4'b0100;
    wrst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_gnt", 32'(gnt), 32'h4);
      chk("fill_waddr", 32'(waddr), 32'(i));
      chk("fill_wdata", 32'(wdata), 32'hC2);
`ifdef FIFO_WR_ALMOST_FULL_EN
      chk("fill_afull", 32'(walmost_full), 32'(i >= 14));
`else
      chk("fill_afull", 32'(walmost_full), 0);
`endif
      chk("fill_wfull", 32'(wfull), 0);
      tick;
    end
    chk("full_wfull", 32'(wfull), 1);
    chk("full_gnt", 32'(gnt), 0);
    chk("full_winc", 32'(winc), 0);
    chk("full_wptr", 32'(wptr), 32'h18);
`ifdef FIFO_WR_ALMOST_FULL_EN
    chk("full_afull", 32'(walmost_full), 1);
`else
    chk("full_afull", 32'(walmost_full), 0);
`endif
    wq2_rptr = 5'b00001;
    #1;
    chk("drain_gnt_pre", 32'(gnt), 0);
    tick;
    chk("drain_wfull", 32'(wfull), 0);
    chk("drain_gnt", 32'(gnt), 32'h4);
    chk("drain_waddr", 32'(waddr), 0);
    tick;
    chk("wrap_wptr", 32'(wptr), 32'h19);
    chk("wrap_wfull", 32'(wfull), 1);
    wrst_n = 1'b0;
    tick;
    wrst_n = 1'b1;
    wq2_rptr = '0;
    req = 4'b1010;
    #1;
    chk("skip_gnt0", 32'(gnt), 32'h2);
    tick;
    chk("skip_gnt1", 32'(gnt), 32'h8);
    tick;
    chk("skip_gnt2", 32'(gnt), 32'h2);
    tick;
    req = '0;
    #1;
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_winc", 32'(winc), 0);
    tick;
    tick;
    req = 4'hF;
    #1;
    chk("hold_gnt", 32'(gnt), 32'h4);
    chk("hold_wdata", 32'(wdata), 32'hC2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
